// File: rtl/iram_port_arbiter.sv
// rtl/iram_port_arbiter.sv - single-port iRAM arbiter for loader writes, CPU fetch and debug readback
module iram_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 24,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_paused,
    input  logic              ld_wr_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rd_valid,
    input  logic              dbg_rd_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rd_data,
    output logic              dbg_ack,
    output logic              wr_blocked,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, HOLD} state_t;
    typedef enum logic [1:0] {OWN_LD, OWN_CPU, OWN_DBG} owner_t;

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic              ld_ack_nxt, cpu_rd_valid_nxt, dbg_ack_nxt, wr_blocked_nxt;
    logic              ram_en_nxt, ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_nxt, cpu_rd_data_nxt, dbg_rd_data_nxt;
    logic              starved;

    assign starved = (starve_cnt == 4'(STARVE_LIMIT));

    // Next-state, arbitration and registered-output values; RAM strobes and CPU valid default low
    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        starve_nxt       = starve_cnt;
        ld_ack_nxt       = ld_ack;
        dbg_ack_nxt      = dbg_ack;
        cpu_rd_valid_nxt = 1'b0;
        cpu_rd_data_nxt  = cpu_rd_data;
        dbg_rd_data_nxt  = dbg_rd_data;
        ram_en_nxt       = 1'b0;
        ram_we_nxt       = 1'b0;
        ram_addr_nxt     = ram_addr;
        ram_wdata_nxt    = ram_wdata;
        wr_blocked_nxt   = wr_blocked | (ld_wr_req & ~cpu_paused);

        if (!dbg_rd_req) begin
            starve_nxt = 4'd0;
        end

        case (state)
            IDLE: begin
                if (dbg_rd_req && starved) begin
                    owner_nxt    = OWN_DBG;
                    ram_en_nxt   = 1'b1;
                    ram_addr_nxt = dbg_addr;
                    starve_nxt   = 4'd0;
                    state_nxt    = ACCESS;
                end else if (ld_wr_req && cpu_paused) begin
                    owner_nxt     = OWN_LD;
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = 1'b1;
                    ram_addr_nxt  = ld_addr;
                    ram_wdata_nxt = ld_data;
                    state_nxt     = ACCESS;
                end else if (cpu_rd_req) begin
                    owner_nxt    = OWN_CPU;
                    ram_en_nxt   = 1'b1;
                    ram_addr_nxt = cpu_rd_addr;
                    state_nxt    = ACCESS;
                end else if (dbg_rd_req) begin
                    owner_nxt    = OWN_DBG;
                    ram_en_nxt   = 1'b1;
                    ram_addr_nxt = dbg_addr;
                    starve_nxt   = 4'd0;
                    state_nxt    = ACCESS;
                end
                // Debug lost to a higher-priority requester this edge
                if (dbg_rd_req && !starved && ((ld_wr_req && cpu_paused) || cpu_rd_req)) begin
                    if (starve_cnt != 4'hF) begin
                        starve_nxt = starve_cnt + 4'd1;
                    end
                end
            end
            ACCESS: begin
                if (owner == OWN_LD) begin
                    ld_ack_nxt = 1'b1;
                    state_nxt  = HOLD;
                end else begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (owner == OWN_CPU) begin
                    cpu_rd_data_nxt  = ram_rdata;
                    cpu_rd_valid_nxt = 1'b1;
                    state_nxt        = IDLE;
                end else begin
                    dbg_rd_data_nxt = ram_rdata;
                    dbg_ack_nxt     = 1'b1;
                    state_nxt       = HOLD;
                end
            end
            HOLD: begin
                if (owner == OWN_LD && !ld_wr_req) begin
                    ld_ack_nxt = 1'b0;
                    state_nxt  = IDLE;
                end else if (owner == OWN_DBG && !dbg_rd_req) begin
                    dbg_ack_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight access silently
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= OWN_LD;
            starve_cnt   <= 4'd0;
            ld_ack       <= 1'b0;
            cpu_rd_data  <= '0;
            cpu_rd_valid <= 1'b0;
            dbg_rd_data  <= '0;
            dbg_ack      <= 1'b0;
            wr_blocked   <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            starve_cnt   <= starve_nxt;
            ld_ack       <= ld_ack_nxt;
            cpu_rd_data  <= cpu_rd_data_nxt;
            cpu_rd_valid <= cpu_rd_valid_nxt;
            dbg_rd_data  <= dbg_rd_data_nxt;
            dbg_ack      <= dbg_ack_nxt;
            wr_blocked   <= wr_blocked_nxt;
            ram_en       <= ram_en_nxt;
            ram_we       <= ram_we_nxt;
            ram_addr     <= ram_addr_nxt;
            ram_wdata    <= ram_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_iram_port_arbiter.sv
// tb/tb_iram_port_arbiter.sv - self-checking bench for iram_port_arbiter
module tb_iram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_paused = 1'b0;
    logic        ld_wr_req = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [23:0] ld_data = '0;
    logic        ld_ack;
    logic        cpu_rd_req = 1'b0;
    logic [7:0]  cpu_rd_addr = '0;
    logic [23:0] cpu_rd_data;
    logic        cpu_rd_valid;
    logic        dbg_rd_req = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [23:0] dbg_rd_data;
    logic        dbg_ack;
    logic        wr_blocked;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata = '0;

    logic [23:0] mem [256];
    logic [23:0] ref_mem [256];
    logic [23:0] cpu_q [$];
    logic [23:0] dbg_q [$];
    logic [23:0] exp_w;
    int checks = 0;
    int failures = 0;

    iram_port_arbiter dut (
        .clk(clk), .rst(rst), .cpu_paused(cpu_paused),
        .ld_wr_req(ld_wr_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data(cpu_rd_data),
        .cpu_rd_valid(cpu_rd_valid), .dbg_rd_req(dbg_rd_req), .dbg_addr(dbg_addr),
        .dbg_rd_data(dbg_rd_data), .dbg_ack(dbg_ack), .wr_blocked(wr_blocked),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, read-first
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    function automatic logic [23:0] init_word(input int i);
        logic [7:0] a;
        a = i[7:0];
        return {a, ~a, a ^ 8'h5A};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({ld_ack, cpu_rd_data, cpu_rd_valid, dbg_rd_data, dbg_ack, wr_blocked,
             ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got nonzero outputs ram_en=%b ld_ack=%b, required all 0", ram_en, ld_ack);
        end
        rst = 1'b1;
        cpu_paused = 1'b0; ld_wr_req = 1'b1; ld_addr = 8'h07; ld_data = 24'h111111;
        tick();
        checks++;
        if (wr_blocked !== 1'b1) begin failures++; $display("FAIL reset_pre_blocked: got %b required 1", wr_blocked); end
        cpu_paused = 1'b1;
        tick();
        checks++;
        if ({ram_en, ram_we} !== 2'b11) begin failures++; $display("FAIL reset_pre_grant: got %b required 11", {ram_en, ram_we}); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ld_ack, wr_blocked, ram_en, ram_we, cpu_rd_valid, dbg_ack} !== 6'b0) begin
                failures++;
                $display("FAIL reset_mid_access: got %b required 000000", {ld_ack, wr_blocked, ram_en, ram_we, cpu_rd_valid, dbg_ack});
            end
        end
        ld_wr_req = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({ld_ack, wr_blocked, ram_en} !== 3'b0) begin failures++; $display("FAIL reset_release: got %b required 000", {ld_ack, wr_blocked, ram_en}); end
    endtask

    task automatic test_loader_write();
        cpu_paused = 1'b1; ld_addr = 8'h05; ld_data = 24'hABCDEF; ld_wr_req = 1'b1;
        ref_mem[8'h05] = 24'hABCDEF;
        tick();
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 8'h05, 24'hABCDEF}) begin
            failures++;
            $display("FAIL ld_access: got en=%b we=%b addr=%h data=%h required 1 1 05 abcdef", ram_en, ram_we, ram_addr, ram_wdata);
        end
        ld_addr = 8'h99; ld_data = 24'h000000;
        tick();
        checks++;
        if ({ram_en, ram_we, ld_ack} !== 3'b001) begin failures++; $display("FAIL ld_ack_rise: got %b required 001", {ram_en, ram_we, ld_ack}); end
        tick(); tick();
        checks++;
        if (ld_ack !== 1'b1) begin failures++; $display("FAIL ld_ack_hold: got %b required 1", ld_ack); end
        ld_wr_req = 1'b0;
        tick();
        checks++;
        if (ld_ack !== 1'b0) begin failures++; $display("FAIL ld_ack_drop: got %b required 0", ld_ack); end
        cpu_paused = 1'b0;
        cpu_rd_addr = 8'h05; cpu_rd_req = 1'b1;
        cpu_q.push_back(ref_mem[8'h05]);
        tick();
        cpu_rd_req = 1'b0;
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {2'b10, 8'h05}) begin failures++; $display("FAIL fetch_grant: got %b %h required 10 05", {ram_en, ram_we}, ram_addr); end
        tick();
        checks++;
        if (cpu_rd_valid !== 1'b0) begin failures++; $display("FAIL fetch_early: got %b required 0", cpu_rd_valid); end
        tick();
        checks++;
        if (cpu_rd_valid !== 1'b1) begin
            failures++; $display("FAIL fetch_latency: valid got %b required 1", cpu_rd_valid);
        end else begin
            exp_w = cpu_q.pop_front();
            if (cpu_rd_data !== exp_w) begin failures++; $display("FAIL fetch_data: got %h required %h", cpu_rd_data, exp_w); end
        end
        tick();
        checks++;
        if (cpu_rd_valid !== 1'b0 || cpu_rd_data !== 24'hABCDEF) begin
            failures++; $display("FAIL fetch_pulse: valid=%b data=%h required 0 abcdef", cpu_rd_valid, cpu_rd_data);
        end
    endtask

    task automatic test_blocked_write();
        bit saw_we = 1'b0;
        cpu_paused = 1'b0; ld_addr = 8'h20; ld_data = 24'h777777; ld_wr_req = 1'b1;
        tick();
        checks++;
        if (wr_blocked !== 1'b1) begin failures++; $display("FAIL blocked_flag: got %b required 1", wr_blocked); end
        cpu_rd_addr = 8'h20; cpu_rd_req = 1'b1;
        cpu_q.push_back(ref_mem[8'h20]);
        for (int i = 0; i < 8; i++) begin
            tick();
            cpu_rd_req = 1'b0;
            if (ram_we || ld_ack) saw_we = 1'b1;
            if (cpu_rd_valid) begin
                checks++;
                exp_w = (cpu_q.size() != 0) ? cpu_q.pop_front() : 24'hx;
                if (cpu_rd_data !== exp_w) begin failures++; $display("FAIL blocked_fetch: got %h required %h", cpu_rd_data, exp_w); end
            end
        end
        checks++;
        if (saw_we !== 1'b0 || cpu_q.size() != 0) begin
            failures++; $display("FAIL blocked_no_write: saw_we=%b pending=%0d required 0 0", saw_we, cpu_q.size());
        end
        ld_wr_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        cpu_paused = 1'b1;
        ld_addr = 8'h10; ld_data = 24'h123456; ld_wr_req = 1'b1;
        cpu_rd_addr = 8'h10; cpu_rd_req = 1'b1;
        ref_mem[8'h10] = 24'h123456;
        cpu_q.push_back(ref_mem[8'h10]);
        tick();
        checks++;
        if ({ram_en, ram_we} !== 2'b11) begin failures++; $display("FAIL cont_write_first: got %b required 11", {ram_en, ram_we}); end
        tick(); tick(); tick();
        checks++;
        if ({ld_ack, ram_en} !== 2'b10) begin failures++; $display("FAIL cont_hold: got %b required 10", {ld_ack, ram_en}); end
        ld_wr_req = 1'b0;
        tick();
        checks++;
        if ({ld_ack, ram_en} !== 2'b00) begin failures++; $display("FAIL cont_hold_exit: got %b required 00", {ld_ack, ram_en}); end
        tick();
        cpu_rd_req = 1'b0;
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {2'b10, 8'h10}) begin failures++; $display("FAIL cont_fetch_grant: got %b %h required 10 10", {ram_en, ram_we}, ram_addr); end
        tick(); tick();
        checks++;
        if (cpu_rd_valid !== 1'b1) begin
            failures++; $display("FAIL cont_fetch_valid: got %b required 1", cpu_rd_valid);
        end else begin
            exp_w = cpu_q.pop_front();
            if (cpu_rd_data !== exp_w) begin failures++; $display("FAIL cont_fetch_data: got %h required %h", cpu_rd_data, exp_w); end
        end
        cpu_paused = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int n_cpu = 0;
        bit got = 1'b0;
        cpu_rd_addr = 8'h05; cpu_rd_req = 1'b1;
        dbg_addr = 8'hFF; dbg_rd_req = 1'b1;
        for (int i = 0; i < 15; i++) cpu_q.push_back(ref_mem[8'h05]);
        dbg_q.push_back(ref_mem[8'hFF]);
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (cpu_rd_valid) begin
                n_cpu++;
                checks++;
                exp_w = (cpu_q.size() != 0) ? cpu_q.pop_front() : 24'hx;
                if (cpu_rd_data !== exp_w) begin failures++; $display("FAIL starve_cpu_data: got %h required %h", cpu_rd_data, exp_w); end
            end
            if (dbg_ack) got = 1'b1;
        end
        checks++;
        if (!got || n_cpu != 15) begin failures++; $display("FAIL starve_count: dbg_ack=%b cpu_fetches=%0d required 1 15", got, n_cpu); end
        checks++;
        exp_w = (dbg_q.size() != 0) ? dbg_q.pop_front() : 24'hx;
        if (dbg_rd_data !== exp_w) begin failures++; $display("FAIL starve_dbg_data: got %h required %h", dbg_rd_data, exp_w); end
        tick(); tick();
        checks++;
        if ({dbg_ack, ram_en} !== 2'b10) begin failures++; $display("FAIL starve_dbg_hold: got %b required 10", {dbg_ack, ram_en}); end
        dbg_rd_req = 1'b0; cpu_rd_req = 1'b0;
        tick();
        checks++;
        if (dbg_ack !== 1'b0) begin failures++; $display("FAIL starve_dbg_drop: got %b required 0", dbg_ack); end
        // With the counter cleared, a fresh CPU+debug pair goes to the CPU first
        cpu_rd_req = 1'b1; dbg_rd_req = 1'b1; dbg_addr = 8'h42;
        cpu_q.push_back(ref_mem[8'h05]);
        dbg_q.push_back(ref_mem[8'h42]);
        tick();
        cpu_rd_req = 1'b0;
        checks++;
        if (ram_addr !== 8'h05) begin failures++; $display("FAIL starve_cleared: first grant addr %h required 05", ram_addr); end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (cpu_rd_valid) begin
                checks++;
                exp_w = (cpu_q.size() != 0) ? cpu_q.pop_front() : 24'hx;
                if (cpu_rd_data !== exp_w) begin failures++; $display("FAIL starve_post_cpu: got %h required %h", cpu_rd_data, exp_w); end
            end
            if (dbg_ack) got = 1'b1;
        end
        checks++;
        exp_w = (dbg_q.size() != 0) ? dbg_q.pop_front() : 24'hx;
        if (!got || dbg_rd_data !== exp_w || cpu_q.size() != 0) begin
            failures++; $display("FAIL starve_post_dbg: ack=%b data=%h required 1 %h", got, dbg_rd_data, exp_w);
        end
        dbg_rd_req = 1'b0;
        tick();
    endtask

    task automatic test_withdrawal();
        dbg_addr = 8'h33; dbg_rd_req = 1'b1;
        dbg_q.push_back(ref_mem[8'h33]);
        tick();
        dbg_rd_req = 1'b0; dbg_addr = 8'h00;
        checks++;
        if ({ram_en, ram_addr} !== {1'b1, 8'h33}) begin failures++; $display("FAIL wd_grant: got %b %h required 1 33", ram_en, ram_addr); end
        tick(); tick();
        checks++;
        exp_w = (dbg_q.size() != 0) ? dbg_q.pop_front() : 24'hx;
        if (dbg_ack !== 1'b1 || dbg_rd_data !== exp_w) begin
            failures++; $display("FAIL wd_ack: ack=%b data=%h required 1 %h", dbg_ack, dbg_rd_data, exp_w);
        end
        tick();
        checks++;
        if ({dbg_ack, ram_en} !== 2'b00 || dbg_rd_data !== exp_w) begin
            failures++; $display("FAIL wd_pulse: ack=%b en=%b data=%h required 0 0 %h", dbg_ack, ram_en, dbg_rd_data, exp_w);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        test_reset();
        test_loader_write();
        test_blocked_write();
        test_contention();
        test_starvation();
        test_withdrawal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iram_port_arbiter.md
Name: iram_port_arbiter

Overview:
Single-port iRAM access controller. It shares one synchronous-read iRAM between three requesters: instruction-loader writes, CPU instruction fetch and debug readback.
It sits between cpu_instruction_loader / CPU fetch / UART debug path and the iRAM macro. It serialises accesses, generates each requester's ack/valid and blocks loader writes while the CPU runs.

Parameters:
ADDR_W, 8, iRAM address width
DATA_W, 24, iRAM word width
STARVE_LIMIT, 15, consecutive lost arbitrations before debug is promoted to top priority (4-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low (asserted when 0)
cpu_paused  in  1  CPU halted; loader writes allowed only when 1
ld_wr_req  in  1  loader write request (level, held until ld_ack)
ld_addr  in  ADDR_W  write address, stable while ld_wr_req=1
ld_data  in  DATA_W  write data, stable while ld_wr_req=1
ld_ack  out  1  write done; held until ld_wr_req drops
cpu_rd_req  in  1  fetch request (level)
cpu_rd_addr  in  ADDR_W  fetch address (PC)
cpu_rd_data  out  DATA_W  fetched word
cpu_rd_valid  out  1  one-cycle pulse, cpu_rd_data valid
dbg_rd_req  in  1  debug read request (level, held until dbg_ack)
dbg_addr  in  ADDR_W  debug read address
dbg_rd_data  out  DATA_W  debug read word
dbg_ack  out  1  dbg_rd_data valid; held until dbg_rd_req drops
wr_blocked  out  1  sticky: loader requested while cpu_paused=0
ram_en  out  1  iRAM enable
ram_we  out  1  iRAM write enable
ram_addr  out  ADDR_W  iRAM address
ram_wdata  out  DATA_W  iRAM write data
ram_rdata  in  DATA_W  iRAM read data, valid the cycle after the access edge

Behaviour:
- All outputs are registered. When rst=0 at an edge: state=IDLE; every output=0; starve counter=0; any in-flight access is dropped with no ack. The RAM write is not retried.
- States: IDLE, ACCESS, CAPTURE, HOLD.
- IDLE arbitration at each edge, in descending priority:
  (1) dbg_rd_req, when starve counter == STARVE_LIMIT;
  (2) ld_wr_req, when cpu_paused=1;
  (3) cpu_rd_req;
  (4) dbg_rd_req.
  On grant: latch owner; drive ram_en=1, ram_addr and ram_we/ram_wdata (write only); go to ACCESS. With no request, ram_en=0 and state stays IDLE.
- ld_wr_req with cpu_paused=0 is never granted and sets wr_blocked=1. wr_blocked clears only on reset.
- Starve counter:
  - increments (saturating) on each edge in IDLE where dbg_rd_req=1 and another requester is granted;
  - clears on a debug grant, and when dbg_rd_req=0.
- ACCESS (1 cycle): ram_en/ram_we drop to 0 at the exit edge.
  - Write: ld_ack<=1, go to HOLD.
  - Read: go to CAPTURE.
- CAPTURE (1 cycle): register ram_rdata into cpu_rd_data or dbg_rd_data.
  - CPU: cpu_rd_valid<=1 for exactly one cycle, then IDLE.
  - Debug: dbg_ack<=1, go to HOLD.
- HOLD: ack stays 1 until the owner's request is sampled 0. That ack then clears and state goes to IDLE. A new grant is possible on the following edge. This is four-phase; no request is re-serviced without a low phase.
- Latency (request sampled at edge N in IDLE, no contention):
  - ram_en high after N;
  - ld_ack high after N+1;
  - cpu_rd_valid/dbg_ack high after N+2.
  - CPU fetch throughput is 1 word per 3 cycles.
- cpu_rd_data/dbg_rd_data hold their last value until overwritten.
- cpu_paused falling during a granted write: the write completes and is acked (grant-time check only).
- Request withdrawn after grant: the access still completes. The ack/valid is still produced, and HOLD exits immediately.
- Address/data are sampled only at grant. Later input changes do not affect the current access.
- Address wrap is the requester's concern. Arbiter passes addresses unmodified; 8'hFF is valid.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-ACCESS of a write -> all outputs 0, no ld_ack, state IDLE; wr_blocked cleared.
- Loader write: cpu_paused=1, ld_addr=8'h05, ld_data=24'hABCDEF -> ram_en=ram_we=1, addr 05, data ABCDEF for one cycle. ld_ack rises next cycle and holds until ld_wr_req drops. A later CPU fetch of 05 returns ABCDEF with cpu_rd_valid at N+2.
- Blocked write: cpu_paused=0, ld_wr_req=1 -> no ram_we ever; wr_blocked=1 after one edge; CPU fetches still serviced.
- Contention: cpu_paused=1, ld_wr_req and cpu_rd_req rise the same cycle -> write granted first, fetch granted after the loader's HOLD exits.
- Starvation: cpu_rd_req held continuously with dbg_rd_req=1, dbg_addr=8'hFF -> debug granted after exactly 15 lost arbitrations. dbg_rd_data=word at FF, dbg_ack held until dbg_rd_req=0, counter back to 0.
- Withdrawal: dbg_rd_req dropped in ACCESS -> dbg_ack pulses one cycle, then IDLE.
